riscv_prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle `riscv` core. It receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them into the instruction memory write port. It verifies a trailing checksum and then releases the core from reset. While loading, or on any error, the core is held in reset.

---
 rtl/riscv_prog_loader_if.sv | 58 +++++
 rtl/riscv_prog_loader.sv | 179 +++++++++++++++++
 tb/tb_riscv_prog_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_prog_loader_if.sv
// Bundle of the loader's byte-stream, instruction-memory write and status signals.
//
// Signals:
//   in_valid / in_data / in_ready : byte-stream handshake, byte taken when valid && ready
//   reload                        : single-cycle request to restart loading (RUN/ERROR only)
//   imem_we / imem_addr / imem_wdata : instruction-memory write port
//   core_reset                    : active-high reset to the riscv core
//   done / error                  : load outcome flags
//   words_loaded                  : number of words written so far
//
// Modports:
//   master : host/environment side (drives the stream and reload, observes everything else)
//   slave  : loader side
interface riscv_prog_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
) ();

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  reload;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_reset;
  logic                  done;
  logic                  error;
  logic [ADDR_WIDTH:0]   words_loaded;

  modport master (
    output in_valid,
    output in_data,
    output reload,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata,
    input  core_reset,
    input  done,
    input  error,
    input  words_loaded
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  reload,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata,
    output core_reset,
    output done,
    output error,
    output words_loaded
  );

endinterface

// File: rtl/riscv_prog_loader.sv
// Boot-time program loader for the single-cycle riscv core.
//
// Receives a framed byte stream (16-bit LE word count, N little-endian 32-bit words, one
// checksum byte equal to the mod-256 sum of all preceding frame bytes), writes each word to
// the instruction memory and releases the core from reset once the checksum matches.
// The core stays in reset while loading and after any error.
//
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, clears all state
//   bus   : riscv_prog_loader_if.slave (byte stream, reload, imem write port, status)
module riscv_prog_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input logic               clock,
  input logic               reset,
  riscv_prog_loader_if.slave bus
);

  localparam int unsigned MaxWords = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    StHdrLo,
    StHdrHi,
    StData,
    StCsum,
    StRun,
    StError
  } state_e;

  state_e state_q, state_d;

  logic [15:0]           count_q, count_d;        // N from the header
  logic [15:0]           word_cnt_q, word_cnt_d;  // words written so far
  logic [1:0]            byte_cnt_q, byte_cnt_d;  // byte position inside the current word
  logic [23:0]           shift_q, shift_d;        // first three bytes of the current word
  logic [7:0]            sum_q, sum_d;            // running checksum, wraps mod 256
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_reset_q, core_reset_d;
  logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;

  logic        in_ready;
  logic        accept;
  logic [15:0] hdr_count;
  logic [31:0] word_full;
  logic [15:0] word_cnt_inc;

  // in_ready is a pure decode of the current state.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StHdrLo, StHdrHi, StData, StCsum: in_ready = 1'b1;
      default:                          in_ready = 1'b0;
    endcase
  end

  assign accept       = bus.in_valid && in_ready;
  assign hdr_count    = {bus.in_data, count_q[7:0]};
  // Bytes arrive LSB first, so the incoming byte is the top byte of the completed word.
  assign word_full    = {bus.in_data, shift_q};
  assign word_cnt_inc = word_cnt_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    word_cnt_d     = word_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    shift_d        = shift_q;
    sum_d          = sum_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    words_loaded_d = words_loaded_q;

    unique case (state_q)
      StHdrLo: begin
        if (accept) begin
          count_d = {8'h00, bus.in_data};
          sum_d   = sum_q + bus.in_data;
          state_d = StHdrHi;
        end
      end

      StHdrHi: begin
        if (accept) begin
          count_d = hdr_count;
          sum_d   = sum_q + bus.in_data;
          if (32'(hdr_count) > MaxWords) begin
            state_d = StError;
          end else if (hdr_count == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end

      StData: begin
        if (accept) begin
          sum_d      = sum_q + bus.in_data;
          shift_d    = {bus.in_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d      = 1'b1;
            imem_addr_d    = word_cnt_q[ADDR_WIDTH-1:0];
            imem_wdata_d   = word_full;
            words_loaded_d = word_cnt_inc[ADDR_WIDTH:0];
            word_cnt_d     = word_cnt_inc;
            if (word_cnt_inc == count_q) begin
              state_d = StCsum;
            end
          end
        end
      end

      StCsum: begin
        if (accept) begin
          state_d = (bus.in_data == sum_q) ? StRun : StError;
        end
      end

      StRun, StError: begin
        if (bus.reload) begin
          state_d        = StHdrLo;
          count_d        = 16'd0;
          word_cnt_d     = 16'd0;
          byte_cnt_d     = 2'd0;
          sum_d          = 8'd0;
          words_loaded_d = '0;
        end
      end

      default: state_d = StHdrLo;
    endcase

    // Core runs only in RUN; registering from state_d releases it on the checksum edge.
    core_reset_d = (state_d != StRun);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StHdrLo;
      count_q        <= 16'd0;
      word_cnt_q     <= 16'd0;
      byte_cnt_q     <= 2'd0;
      shift_q        <= 24'd0;
      sum_q          <= 8'd0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= 32'd0;
      core_reset_q   <= 1'b1;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      word_cnt_q     <= word_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      shift_q        <= shift_d;
      sum_q          <= sum_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      core_reset_q   <= core_reset_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.imem_we      = imem_we_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.imem_wdata   = imem_wdata_q;
  assign bus.core_reset   = core_reset_q;
  assign bus.done         = (state_q == StRun);
  assign bus.error        = (state_q == StError);
  assign bus.words_loaded = words_loaded_q;

endmodule

// File: tb/tb_riscv_prog_loader.sv
// Self-checking bench for riscv_prog_loader: directed frames plus random frames, each checked
// against a frame-level reference model (header parse, word assembly, mod-256 checksum).
module tb_riscv_prog_loader;

  localparam int unsigned AW       = 8;
  localparam int          MaxWords = 256;

  logic clock = 1'b0;
  logic reset = 1'b1;

  riscv_prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

  riscv_prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  frame[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          got_addr[$];
  logic [31:0] got_data[$];
  int          exp_consumed;
  bit          exp_done;
  int          exp_loaded;

  // Write monitor: each imem_we pulse lasts one cycle, so one negedge sample per write.
  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      got_addr.push_back(int'(bus.imem_addr));
      got_data.push_back(bus.imem_wdata);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what a frame should do, derived from the frame rules alone.
  task automatic model_frame();
    int n;
    int sum;
    exp_addr.delete();
    exp_data.delete();
    n = int'(frame[0]) + 256 * int'(frame[1]);
    if (n > MaxWords) begin
      exp_consumed = 2;
      exp_done     = 1'b0;
      exp_loaded   = 0;
      return;
    end
    sum = 0;
    for (int i = 0; i < 2 + 4 * n; i++) sum += int'(frame[i]);
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back(k);
      exp_data.push_back(32'(frame[2 + 4 * k]) + 32'(frame[3 + 4 * k]) * 32'd256 +
                         32'(frame[4 + 4 * k]) * 32'd65536 +
                         32'(frame[5 + 4 * k]) * 32'd16777216);
    end
    exp_consumed = 3 + 4 * n;
    exp_done     = (int'(frame[2 + 4 * n]) == sum % 256);
    exp_loaded   = n;
  endtask

  task automatic build_frame(input int n, input bit corrupt);
    int sum;
    frame.delete();
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    if (n <= MaxWords) begin
      for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
    end
    sum = 0;
    foreach (frame[i]) sum += int'(frame[i]);
    if (corrupt) sum += 1 + int'($urandom_range(253));
    frame.push_back(8'(sum));
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit took;
    int waited;
    for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clock);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    took   = 1'b0;
    waited = 0;
    while (!took && waited < 20) begin
      took = bus.in_ready;
      @(negedge clock);
      waited++;
    end
    bus.in_valid = 1'b0;
    if (!took) check("accept_timeout", 64'(took), 64'd1);
  endtask

  task automatic check_outcome(input string name);
    repeat (3) @(negedge clock);
    check({name, "_nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      check($sformatf("%s_addr%0d", name, k), 64'(got_addr[k]), 64'(exp_addr[k]));
      check($sformatf("%s_data%0d", name, k), 64'(got_data[k]), 64'(exp_data[k]));
    end
    check({name, "_done"}, 64'(bus.done), 64'(exp_done));
    check({name, "_error"}, 64'(bus.error), 64'(!exp_done));
    check({name, "_core_reset"}, 64'(bus.core_reset), 64'(!exp_done));
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({name, "_words_loaded"}, 64'(bus.words_loaded), 64'(exp_loaded));
  endtask

  task automatic run_frame(input string name, input int gap_pct);
    model_frame();
    got_addr.delete();
    got_data.delete();
    for (int i = 0; i < exp_consumed; i++) send_byte(frame[i], gap_pct);
    check_outcome(name);
  endtask

  // Reload with a coincident valid byte that must not be consumed.
  task automatic do_reload(input string name);
    bus.reload   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    @(negedge clock);
    bus.reload   = 1'b0;
    bus.in_valid = 1'b0;
    check({name, "_core_reset"}, 64'(bus.core_reset), 64'd1);
    check({name, "_done"}, 64'(bus.done), 64'd0);
    check({name, "_error"}, 64'(bus.error), 64'd0);
    check({name, "_words_loaded"}, 64'(bus.words_loaded), 64'd0);
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({name, "_we"}, 64'(bus.imem_we), 64'd0);
    check({name, "_addr"}, 64'(bus.imem_addr), 64'd0);
    check({name, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
    check({name, "_core_reset"}, 64'(bus.core_reset), 64'd1);
    check({name, "_done"}, 64'(bus.done), 64'd0);
    check({name, "_error"}, 64'(bus.error), 64'd0);
    check({name, "_words_loaded"}, 64'(bus.words_loaded), 64'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.reload   = 1'b0;
    reset        = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_values("por");
    reset = 1'b0;
    @(negedge clock);

    // N=1 with exact write and release latency.
    frame = {8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hE4};
    model_frame();
    for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
    check("n1_we_latency", 64'(bus.imem_we), 64'd1);
    check("n1_addr", 64'(bus.imem_addr), 64'd0);
    check("n1_wdata", 64'(bus.imem_wdata), 64'h0050_0093);
    check("n1_words_loaded_at_write", 64'(bus.words_loaded), 64'd1);
    check("n1_core_reset_held", 64'(bus.core_reset), 64'd1);
    send_byte(frame[6], 0);
    check("n1_release_core_reset", 64'(bus.core_reset), 64'd0);
    check("n1_release_done", 64'(bus.done), 64'd1);
    check("n1_we_dropped", 64'(bus.imem_we), 64'd0);
    check_outcome("n1");

    do_reload("reload1");
    frame = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h99};
    run_frame("n2_gaps", 40);

    do_reload("reload2");
    frame = {8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hE5};
    run_frame("bad_csum", 20);

    do_reload("reload3");
    frame = {8'h00, 8'h00, 8'h00};
    run_frame("empty", 0);

    // Oversize count: error and in_ready fall right after the high header byte.
    do_reload("reload4");
    frame = {8'h2C, 8'h01};
    model_frame();
    got_addr.delete();
    got_data.delete();
    send_byte(frame[0], 0);
    send_byte(frame[1], 0);
    check("oversize_error_now", 64'(bus.error), 64'd1);
    check("oversize_ready_now", 64'(bus.in_ready), 64'd0);
    check_outcome("oversize");

    // Reset in the middle of a word.
    do_reload("reload5");
    frame = {8'h01, 8'h00, 8'h93, 8'h00};
    for (int i = 0; i < 4; i++) send_byte(frame[i], 0);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    frame = {8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hE4};
    run_frame("after_reset", 0);

    // Reload from RUN, then overwrite addr 0.
    do_reload("reload6");
    frame = {8'h01, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'hB5};
    run_frame("overwrite", 10);

    for (int r = 0; r < 10; r++) begin
      int  n;
      bit  corrupt;
      n       = (r % 5 == 4) ? 257 + int'($urandom_range(2000)) : int'($urandom_range(6));
      corrupt = ($urandom_range(3) == 0);
      do_reload($sformatf("rnd%0d_reload", r));
      build_frame(n, corrupt);
      run_frame($sformatf("rnd%0d", r), 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
